lifo_stack: RTL and testbench

LIFO_STACK -- requirements
Module: lifo_stack

---
 rtl/lifo_stack.sv | 111 +++++++++++
 tb/tb_lifo_stack.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lifo_stack.sv
// Parameterised register-array LIFO with show-ahead top-of-stack output,
// occupancy count, level flags and sticky overflow/underflow error flags.
module lifo_stack #(
  parameter int DATA_WIDTH = 8,
  parameter int LIFO_DEPTH = 8,
  parameter int AF_LEVEL   = LIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  localparam int CW        = $clog2(LIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  syn_rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = $clog2(LIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(LIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (LIFO_DEPTH < 2) begin : g_bad_depth
    $error("lifo_stack: LIFO_DEPTH must be at least 2");
  end
  if (AF_LEVEL > LIFO_DEPTH || AE_LEVEL > LIFO_DEPTH) begin : g_bad_levels
    $error("lifo_stack: AF_LEVEL and AE_LEVEL must not exceed LIFO_DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [LIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [LIFO_DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [AW-1:0]         top_idx;
  logic [AW-1:0]         wr_idx;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Indices are only meaningful when the guarding empty/full flag allows it.
  assign top_idx  = empty ? '0 : AW'(count_q - 1'b1);
  assign wr_idx   = full  ? '0 : AW'(count_q);
  assign data_out = empty ? '0 : mem_q[top_idx];

  always_comb begin
    mem_d       = mem_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (push && pop) begin
      if (empty) begin
        mem_d[0]    = data_in;
        count_d     = CW'(1);
        underflow_d = 1'b1;
      end else begin
        mem_d[top_idx] = data_in;
      end
    end else if (push) begin
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        mem_d[wr_idx] = data_in;
        count_d       = count_q + 1'b1;
      end
    end else if (pop) begin
      if (empty) begin
        underflow_d = 1'b1;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (syn_rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Array is never reset; reset only blocks any write pending in that cycle.
  always_ff @(posedge clk) begin
    if (!syn_rst) begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
// Scoreboard bench for lifo_stack: a queue-based stack model predicts every
// cycle's outputs; a monitor compares them against the DUT after each edge.
module tb_lifo_stack;

  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int AF = 7;
  localparam int AE = 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          syn_rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic [CW-1:0] count;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int data;
    int cnt;
    int full;
    int empty;
    int af;
    int ae;
    int ovf;
    int unf;
  } exp_t;

  exp_t exp_q[$];
  int   model[$];
  int   m_ovf = 0;
  int   m_unf = 0;

  lifo_stack #(
    .DATA_WIDTH(DW),
    .LIFO_DEPTH(DEPTH),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk(clk),
    .syn_rst(syn_rst),
    .push(push),
    .pop(pop),
    .clear(clear),
    .data_in(data_in),
    .data_out(data_out),
    .count(count),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Stack model: a plain queue where the back element is the top.
  task automatic model_step(input int p, input int q, input int c, input int r, input int d);
    exp_t e;
    if (r != 0 || c != 0) begin
      model.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (p != 0 && q != 0) begin
      if (model.size() == 0) begin
        model.push_back(d);
        m_unf = 1;
      end else begin
        model[model.size() - 1] = d;
      end
    end else if (p != 0) begin
      if (model.size() == DEPTH) m_ovf = 1;
      else model.push_back(d);
    end else if (q != 0) begin
      if (model.size() == 0) m_unf = 1;
      else void'(model.pop_back());
    end
    e.cnt   = model.size();
    e.data  = (e.cnt > 0) ? model[e.cnt - 1] : 0;
    e.full  = (e.cnt == DEPTH) ? 1 : 0;
    e.empty = (e.cnt == 0) ? 1 : 0;
    e.af    = (e.cnt >= AF) ? 1 : 0;
    e.ae    = (e.cnt <= AE) ? 1 : 0;
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    exp_q.push_back(e);
  endtask

  // Called right after a falling edge; returns at the next falling edge.
  task automatic step(input int p, input int q, input int c, input int r, input int d);
    push    = (p != 0);
    pop     = (q != 0);
    clear   = (c != 0);
    syn_rst = (r != 0);
    data_in = DW'(d);
    @(posedge clk);
    model_step(p, q, c, r, d);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("data_out",     int'(data_out),     e.data);
        chk("count",        int'(count),        e.cnt);
        chk("full",         int'(full),         e.full);
        chk("empty",        int'(empty),        e.empty);
        chk("almost_full",  int'(almost_full),  e.af);
        chk("almost_empty", int'(almost_empty), e.ae);
        chk("overflow",     int'(overflow),     e.ovf);
        chk("underflow",    int'(underflow),    e.unf);
      end
    end
  end

  initial begin : stimulus
    @(negedge clk);
    step(0, 0, 0, 1, 0);
    chk("reset_empty", int'(empty), 1);
    chk("reset_data", int'(data_out), 0);

    // Fill
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 0, 0, i);
      if (i == 7) chk("fill_af_at_7", int'(almost_full), 1);
      if (i == 8) begin
        chk("fill_full", int'(full), 1);
        chk("fill_data8", int'(data_out), 8);
        chk("fill_no_ovf_yet", int'(overflow), 0);
      end
    end
    chk("fill_ovf", int'(overflow), 1);
    chk("fill_count", int'(count), 8);

    // Drain
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 0, 0, 0);
      chk("drain_data", int'(data_out), (i < 8) ? 8 - i : 0);
      if (i == 7) chk("drain_ae_at_1", int'(almost_empty), 1);
      if (i == 8) chk("drain_empty", int'(empty), 1);
    end
    chk("drain_unf", int'(underflow), 1);

    // Replace
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 'h11);
    step(1, 0, 0, 0, 'h22);
    step(1, 1, 0, 0, 'h33);
    chk("replace_count", int'(count), 2);
    chk("replace_data", int'(data_out), 'h33);
    step(0, 1, 0, 0, 0);
    chk("replace_pop_data", int'(data_out), 'h11);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 'h40 + i);
    step(1, 1, 0, 0, 'h99);
    chk("replace_full_count", int'(count), 8);
    chk("replace_full_ovf", int'(overflow), 0);
    chk("replace_full_data", int'(data_out), 'h99);

    // Push+pop on empty
    step(0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 'h5A);
    chk("epp_count", int'(count), 1);
    chk("epp_data", int'(data_out), 'h5A);
    chk("epp_unf", int'(underflow), 1);

    // Clear and reset mid-operation with count=5 and both flags set
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 'h70 + i);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
      chk("pre_flush_count", int'(count), 5);
      if (k == 0) step(1, 0, 1, 0, 'hEE);
      else        step(1, 1, 0, 1, 'hEE);
      chk("flush_count", int'(count), 0);
      chk("flush_data", int'(data_out), 0);
      chk("flush_ovf", int'(overflow), 0);
      chk("flush_unf", int'(underflow), 0);
    end

    // Random
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) < 40) ? 1 : 0,
           ($urandom_range(0, 99) < 70) ? 1 : 0,
           ($urandom_range(0, 99) < 1) ? 1 : 0,
           ($urandom_range(0, 199) < 1) ? 1 : 0,
           int'($urandom_range(0, 255)));
    end

    step(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
